// File: rtl/tomasulo_pkg.sv
`default_nettype none
// ============================================================================
// Module   : tomasulo_pkg
// Desc     : Shared widths, the "no producer" tag and the reorder-buffer
//            entry record used by the Tomasulo core blocks.
// Revision : 1.0 - initial release
// ============================================================================
package tomasulo_pkg;

  localparam int TAG_W  = 4;
  localparam int REG_W  = 5;
  localparam int DATA_W = 32;

  // Tag 0 marks "no producer"; it is never handed to an instruction.
  localparam logic [TAG_W-1:0] NO_TAG = '0;

  typedef struct packed {
    logic              busy;
    logic              done;
    logic [REG_W-1:0]  dest;
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] value;
  } rob_entry_t;

endpackage
`default_nettype wire

// File: rtl/reorder_buf_if.sv
`default_nettype none
// ============================================================================
// Module   : reorder_buf_if
// Desc     : Issue, CDB and commit bundle of the reorder buffer. The master
//            side drives issue/CDB and observes commit and occupancy.
// Revision : 1.0 - initial release
// ============================================================================
interface reorder_buf_if #(
  parameter int PTR_W = 3
) ();

  logic                              issue_valid;
  logic [tomasulo_pkg::REG_W-1:0]    issue_dest;
  logic [tomasulo_pkg::TAG_W-1:0]    issue_tag;
  logic                              issue_ready;

  logic                              cdb_valid;
  logic [tomasulo_pkg::TAG_W-1:0]    cdb_tag;
  logic [tomasulo_pkg::DATA_W-1:0]   cdb_value;

  logic                              commit;
  logic [tomasulo_pkg::REG_W-1:0]    commit_dest;
  logic [tomasulo_pkg::TAG_W-1:0]    commit_tag;
  logic [tomasulo_pkg::DATA_W-1:0]   commit_value;

  logic [PTR_W:0]                    count;
  logic                              empty;

  modport master (
    output issue_valid, issue_dest, issue_tag,
    output cdb_valid, cdb_tag, cdb_value,
    input  issue_ready, commit, commit_dest, commit_tag, commit_value,
    input  count, empty
  );

  modport slave (
    input  issue_valid, issue_dest, issue_tag,
    input  cdb_valid, cdb_tag, cdb_value,
    output issue_ready, commit, commit_dest, commit_tag, commit_value,
    output count, empty
  );

endinterface
`default_nettype wire

// File: rtl/rob_ptr_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : rob_ptr_ctrl
// Desc     : Head/tail pointers, occupancy count and issue acceptance of the
//            reorder buffer. Pointers wrap naturally at DEPTH (power of two).
// Revision : 1.0 - initial release
// ============================================================================
module rob_ptr_ctrl #(
  parameter int DEPTH = 8,
  parameter int PTR_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_issue_valid,
  input  logic             i_commit,
  output logic [PTR_W-1:0] o_head_ptr,
  output logic [PTR_W-1:0] o_tail_ptr,
  output logic [PTR_W:0]   o_count,
  output logic             o_issue_ready,
  output logic             o_empty,
  output logic             o_issue_fire
);

  localparam logic [PTR_W:0] c_FULL_COUNT = (PTR_W+1)'(DEPTH);

  logic [PTR_W-1:0] r_head_ptr;
  logic [PTR_W-1:0] r_tail_ptr;
  logic [PTR_W:0]   r_count;
  logic             w_issue_ready;
  logic             w_issue_fire;

  // Ready depends only on the registered count, so a full buffer refuses
  // issue even in a cycle where the head is retiring.
  always_comb begin
    w_issue_ready = (r_count != c_FULL_COUNT);
    w_issue_fire  = i_issue_valid & w_issue_ready;
  end

  // Pointer and count registers; simultaneous issue and commit keep count.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_head_ptr <= '0;
      r_tail_ptr <= '0;
      r_count    <= '0;
    end else begin
      if (w_issue_fire) begin
        r_tail_ptr <= r_tail_ptr + PTR_W'(1);
      end
      if (i_commit) begin
        r_head_ptr <= r_head_ptr + PTR_W'(1);
      end
      case ({w_issue_fire, i_commit})
        2'b10:   r_count <= r_count + (PTR_W+1)'(1);
        2'b01:   r_count <= r_count - (PTR_W+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_head_ptr    = r_head_ptr;
  assign o_tail_ptr    = r_tail_ptr;
  assign o_count       = r_count;
  assign o_issue_ready = w_issue_ready;
  assign o_empty       = (r_count == '0);
  assign o_issue_fire  = w_issue_fire;

endmodule
`default_nettype wire

// File: rtl/reorder_buf.sv
`default_nettype none
// ============================================================================
// Module   : reorder_buf
// Desc     : In-order commit buffer. Allocates an entry per issued
//            instruction, captures results from the CDB and retires the
//            head entry once its result is present.
// Revision : 1.0 - initial release
// ============================================================================
module reorder_buf #(
  parameter int DEPTH = 8,
  parameter int PTR_W = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  reorder_buf_if.slave bus
);

  import tomasulo_pkg::*;

  logic [PTR_W-1:0] w_head_ptr;
  logic [PTR_W-1:0] w_tail_ptr;
  logic             w_issue_fire;
  logic             w_commit;
  logic             w_cdb_live;
  rob_entry_t       w_entries [DEPTH];
  rob_entry_t       w_head_entry;

  rob_ptr_ctrl #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_ptr_ctrl (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_issue_valid (bus.issue_valid),
    .i_commit      (w_commit),
    .o_head_ptr    (w_head_ptr),
    .o_tail_ptr    (w_tail_ptr),
    .o_count       (bus.count),
    .o_issue_ready (bus.issue_ready),
    .o_empty       (bus.empty),
    .o_issue_fire  (w_issue_fire)
  );

  // A broadcast on the "no producer" tag never completes anything.
  assign w_cdb_live = bus.cdb_valid & (bus.cdb_tag != NO_TAG);

  for (genvar i = 0; i < DEPTH; i++) begin : g_entry
    localparam logic [PTR_W-1:0] c_IDX = PTR_W'(i);

    rob_entry_t r_entry;
    logic       w_alloc;
    logic       w_retire;
    logic       w_capture;

    // Issue and commit never target the same slot: that would need the
    // buffer to be both empty (no commit) and full (no issue).
    always_comb begin
      w_alloc   = w_issue_fire & (w_tail_ptr == c_IDX);
      w_retire  = w_commit & (w_head_ptr == c_IDX);
      w_capture = w_cdb_live & r_entry.busy & ~r_entry.done &
                  (r_entry.tag == bus.cdb_tag);
    end

    // Entry state; allocation wins, so a same-cycle CDB cannot complete the
    // slot being written (a free slot is not busy and cannot match anyway).
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        r_entry <= '0;
      end else if (w_alloc) begin
        r_entry.busy  <= 1'b1;
        r_entry.done  <= 1'b0;
        r_entry.dest  <= bus.issue_dest;
        r_entry.tag   <= bus.issue_tag;
        r_entry.value <= '0;
      end else if (w_retire) begin
        r_entry.busy <= 1'b0;
        r_entry.done <= 1'b0;
      end else if (w_capture) begin
        r_entry.done  <= 1'b1;
        r_entry.value <= bus.cdb_value;
      end
    end

    assign w_entries[i] = r_entry;
  end

  // Commit decision comes purely from the registered head entry.
  always_comb begin
    w_head_entry = w_entries[w_head_ptr];
    w_commit     = w_head_entry.busy & w_head_entry.done;
  end

  assign bus.commit       = w_commit;
  assign bus.commit_dest  = w_commit ? w_head_entry.dest  : '0;
  assign bus.commit_tag   = w_commit ? w_head_entry.tag   : '0;
  assign bus.commit_value = w_commit ? w_head_entry.value : '0;

endmodule
`default_nettype wire

// File: tb/tb_reorder_buf.sv
`default_nettype none
// ============================================================================
// Module   : tb_reorder_buf
// Desc     : Self-checking bench for reorder_buf: directed scenarios plus a
//            randomized run against a queue-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_reorder_buf;

  import tomasulo_pkg::*;

  localparam int DEPTH = 8;
  localparam int PTR_W = 3;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  reorder_buf_if #(.PTR_W(PTR_W)) bus ();

  reorder_buf #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [REG_W-1:0]  dest;
    logic [TAG_W-1:0]  tag;
    bit                done;
    logic [DATA_W-1:0] value;
  } mentry_t;

  // Program-order list of in-flight instructions; front is the oldest.
  mentry_t mq[$];

  // Advance the model by one clock edge using the inputs presented before it.
  task automatic model_update();
    bit do_commit;
    bit ready;
    do_commit = (mq.size() > 0) && mq[0].done;
    ready     = (mq.size() < DEPTH);
    if (!rst_n) begin
      mq.delete();
      return;
    end
    if (bus.cdb_valid && bus.cdb_tag != NO_TAG) begin
      foreach (mq[k]) begin
        if (!mq[k].done && mq[k].tag == bus.cdb_tag) begin
          mq[k].done  = 1'b1;
          mq[k].value = bus.cdb_value;
        end
      end
    end
    if (do_commit) void'(mq.pop_front());
    if (bus.issue_valid && ready)
      mq.push_back('{bus.issue_dest, bus.issue_tag, 1'b0, 32'h0});
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic drive_idle();
    bus.issue_valid = 1'b0;
    bus.issue_dest  = '0;
    bus.issue_tag   = '0;
    bus.cdb_valid   = 1'b0;
    bus.cdb_tag     = '0;
    bus.cdb_value   = '0;
  endtask

  task automatic drive_issue(input logic [REG_W-1:0] d, input logic [TAG_W-1:0] t);
    bus.issue_valid = 1'b1;
    bus.issue_dest  = d;
    bus.issue_tag   = t;
  endtask

  task automatic drive_cdb(input logic [TAG_W-1:0] t, input logic [DATA_W-1:0] v);
    bus.cdb_valid = 1'b1;
    bus.cdb_tag   = t;
    bus.cdb_value = v;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive_idle();
    step();
    step();
    rst_n = 1'b1;
    n_tests++;
    if ({bus.commit, bus.issue_ready, bus.empty, bus.count} !== {1'b0, 1'b1, 1'b1, 4'd0}) begin
      n_fail++;
      $display("FAIL reset_flags: commit/ready/empty/count=%b/%b/%b/%0d required 0/1/1/0",
               bus.commit, bus.issue_ready, bus.empty, bus.count);
    end
    n_tests++;
    if ({bus.commit_dest, bus.commit_tag, bus.commit_value} !== '0) begin
      n_fail++;
      $display("FAIL reset_commit_fields: dest/tag/value=%0d/%0d/%h required 0/0/0",
               bus.commit_dest, bus.commit_tag, bus.commit_value);
    end
    drive_cdb(4'd3, 32'h1234_5678);
    step();
    drive_idle();
    step();
    n_tests++;
    if ({bus.commit, bus.count, bus.empty} !== {1'b0, 4'd0, 1'b1}) begin
      n_fail++;
      $display("FAIL reset_idle_cdb: commit/count/empty=%b/%0d/%b required 0/0/1",
               bus.commit, bus.count, bus.empty);
    end
  endtask

  task automatic test_single();
    drive_issue(5'd5, 4'd2);
    step();
    drive_idle();
    n_tests++;
    if ({bus.count, bus.commit} !== {4'd1, 1'b0}) begin
      n_fail++;
      $display("FAIL single_alloc: count/commit=%0d/%b required 1/0", bus.count, bus.commit);
    end
    step();
    drive_cdb(4'd2, 32'hDEAD_BEEF);
    step();
    drive_idle();
    n_tests++;
    if ({bus.commit, bus.commit_dest, bus.commit_tag, bus.commit_value} !==
        {1'b1, 5'd5, 4'd2, 32'hDEAD_BEEF}) begin
      n_fail++;
      $display("FAIL single_commit: commit/dest/tag/value=%b/%0d/%0d/%h required 1/5/2/deadbeef",
               bus.commit, bus.commit_dest, bus.commit_tag, bus.commit_value);
    end
    step();
    n_tests++;
    if ({bus.empty, bus.commit} !== {1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL single_empty: empty/commit=%b/%b required 1/0", bus.empty, bus.commit);
    end
  endtask

  task automatic test_out_of_order();
    drive_issue(5'd1, 4'd1);
    step();
    drive_issue(5'd2, 4'd2);
    step();
    drive_idle();
    drive_cdb(4'd2, 32'h0000_2222);
    step();
    drive_idle();
    step();
    n_tests++;
    if (bus.commit !== 1'b0) begin
      n_fail++;
      $display("FAIL ooo_younger_waits: commit=%b required 0", bus.commit);
    end
    drive_cdb(4'd1, 32'h0000_1111);
    step();
    drive_idle();
    n_tests++;
    if ({bus.commit, bus.commit_dest, bus.commit_tag, bus.commit_value} !==
        {1'b1, 5'd1, 4'd1, 32'h0000_1111}) begin
      n_fail++;
      $display("FAIL ooo_first: commit/dest/tag/value=%b/%0d/%0d/%h required 1/1/1/00001111",
               bus.commit, bus.commit_dest, bus.commit_tag, bus.commit_value);
    end
    step();
    n_tests++;
    if ({bus.commit, bus.commit_dest, bus.commit_tag, bus.commit_value} !==
        {1'b1, 5'd2, 4'd2, 32'h0000_2222}) begin
      n_fail++;
      $display("FAIL ooo_second: commit/dest/tag/value=%b/%0d/%0d/%h required 1/2/2/00002222",
               bus.commit, bus.commit_dest, bus.commit_tag, bus.commit_value);
    end
    step();
    n_tests++;
    if (bus.empty !== 1'b1) begin
      n_fail++;
      $display("FAIL ooo_drained: empty=%b required 1", bus.empty);
    end
  endtask

  task automatic test_full();
    logic [DATA_W-1:0] v;
    for (int t = 1; t <= DEPTH; t++) begin
      drive_issue(5'(t + 10), 4'(t));
      step();
    end
    drive_idle();
    n_tests++;
    if ({bus.count, bus.issue_ready} !== {4'd8, 1'b0}) begin
      n_fail++;
      $display("FAIL full_flags: count/ready=%0d/%b required 8/0", bus.count, bus.issue_ready);
    end
    drive_issue(5'd31, 4'd9);
    step();
    drive_idle();
    n_tests++;
    if (bus.count !== 4'd8) begin
      n_fail++;
      $display("FAIL full_ignore_issue: count=%0d required 8", bus.count);
    end
    drive_cdb(4'd1, 32'h0000_00A1);
    step();
    drive_idle();
    n_tests++;
    if ({bus.commit, bus.commit_tag, bus.issue_ready} !== {1'b1, 4'd1, 1'b0}) begin
      n_fail++;
      $display("FAIL full_commit_not_ready: commit/tag/ready=%b/%0d/%b required 1/1/0",
               bus.commit, bus.commit_tag, bus.issue_ready);
    end
    step();
    n_tests++;
    if ({bus.issue_ready, bus.count} !== {1'b1, 4'd7}) begin
      n_fail++;
      $display("FAIL full_ready_after: ready/count=%b/%0d required 1/7", bus.issue_ready, bus.count);
    end
    for (int t = 2; t <= DEPTH; t++) begin
      v = $urandom;
      drive_cdb(4'(t), v);
      step();
      drive_idle();
      n_tests++;
      if ({bus.commit, bus.commit_dest, bus.commit_tag, bus.commit_value} !==
          {1'b1, 5'(t + 10), 4'(t), v}) begin
        n_fail++;
        $display("FAIL full_drain: commit/dest/tag/value=%b/%0d/%0d/%h required 1/%0d/%0d/%h",
                 bus.commit, bus.commit_dest, bus.commit_tag, bus.commit_value, t + 10, t, v);
      end
      step();
    end
    n_tests++;
    if (bus.empty !== 1'b1) begin
      n_fail++;
      $display("FAIL full_drained: empty=%b required 1", bus.empty);
    end
  endtask

  task automatic test_wrap();
    logic [TAG_W-1:0] next_tag;
    next_tag = 4'd1;
    for (int k = 0; k < 3; k++) begin
      drive_issue(5'($urandom), next_tag);
      next_tag = (next_tag == 4'd15) ? 4'd1 : next_tag + 4'd1;
      step();
    end
    drive_idle();
    for (int r = 0; r < 20; r++) begin
      drive_cdb(mq[0].tag, $urandom);
      step();
      drive_idle();
      n_tests++;
      if ({bus.commit, bus.commit_dest, bus.commit_tag, bus.commit_value, bus.count} !==
          {1'b1, mq[0].dest, mq[0].tag, mq[0].value, 4'd3}) begin
        n_fail++;
        $display("FAIL wrap_commit r%0d: commit/dest/tag/value/count=%b/%0d/%0d/%h/%0d required 1/%0d/%0d/%h/3",
                 r, bus.commit, bus.commit_dest, bus.commit_tag, bus.commit_value, bus.count,
                 mq[0].dest, mq[0].tag, mq[0].value);
      end
      drive_issue(5'($urandom), next_tag);
      next_tag = (next_tag == 4'd15) ? 4'd1 : next_tag + 4'd1;
      step();
      drive_idle();
      n_tests++;
      if ({bus.count, bus.commit} !== {4'd3, 1'b0}) begin
        n_fail++;
        $display("FAIL wrap_steady r%0d: count/commit=%0d/%b required 3/0", r, bus.count, bus.commit);
      end
    end
  endtask

  task automatic test_random();
    logic [TAG_W-1:0]  t;
    logic [REG_W-1:0]  exp_d;
    logic [TAG_W-1:0]  exp_t;
    logic [DATA_W-1:0] exp_v;
    bit                exp_c;
    bit                used;
    for (int cyc = 0; cyc < 300; cyc++) begin
      drive_idle();
      if ($urandom_range(0, 9) < 7) begin
        t = 4'($urandom_range(1, 15));
        repeat (16) begin
          used = 1'b0;
          foreach (mq[k]) if (mq[k].tag == t) used = 1'b1;
          if (!used) break;
          t = (t == 4'd15) ? 4'd1 : t + 4'd1;
        end
        drive_issue(5'($urandom), t);
      end
      if ($urandom_range(0, 9) < 6) begin
        if (mq.size() > 0 && $urandom_range(0, 9) < 7)
          drive_cdb(mq[$urandom_range(0, mq.size() - 1)].tag, $urandom);
        else
          drive_cdb(4'($urandom_range(0, 15)), $urandom);
      end
      step();
      exp_c = (mq.size() > 0) && mq[0].done;
      exp_d = exp_c ? mq[0].dest  : '0;
      exp_t = exp_c ? mq[0].tag   : '0;
      exp_v = exp_c ? mq[0].value : '0;
      n_tests++;
      if ({bus.commit, bus.commit_dest, bus.commit_tag, bus.commit_value} !==
          {exp_c, exp_d, exp_t, exp_v}) begin
        n_fail++;
        $display("FAIL rand_commit c%0d: commit/dest/tag/value=%b/%0d/%0d/%h required %b/%0d/%0d/%h",
                 cyc, bus.commit, bus.commit_dest, bus.commit_tag, bus.commit_value,
                 exp_c, exp_d, exp_t, exp_v);
      end
      n_tests++;
      if ({bus.count, bus.issue_ready, bus.empty} !==
          {4'(mq.size()), mq.size() < DEPTH, mq.size() == 0}) begin
        n_fail++;
        $display("FAIL rand_occupancy c%0d: count/ready/empty=%0d/%b/%b required %0d/%b/%b",
                 cyc, bus.count, bus.issue_ready, bus.empty,
                 mq.size(), mq.size() < DEPTH, mq.size() == 0);
      end
    end
    drive_idle();
  endtask

  task automatic test_same_cycle_and_reset();
    rst_n = 1'b0;
    drive_idle();
    step();
    rst_n = 1'b1;
    drive_issue(5'd7, 4'd4);
    drive_cdb(4'd4, 32'h0000_0044);
    step();
    drive_idle();
    step();
    n_tests++;
    if ({bus.count, bus.commit} !== {4'd1, 1'b0}) begin
      n_fail++;
      $display("FAIL same_cycle_cdb: count/commit=%0d/%b required 1/0", bus.count, bus.commit);
    end
    for (int t = 5; t <= 8; t++) begin
      drive_issue(5'(t), 4'(t));
      step();
    end
    drive_idle();
    drive_cdb(4'd4, 32'h0000_0444);
    step();
    drive_idle();
    n_tests++;
    if ({bus.count, bus.commit, bus.commit_value} !== {4'd5, 1'b1, 32'h0000_0444}) begin
      n_fail++;
      $display("FAIL pre_reset: count/commit/value=%0d/%b/%h required 5/1/00000444",
               bus.count, bus.commit, bus.commit_value);
    end
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    n_tests++;
    if ({bus.count, bus.commit, bus.empty, bus.issue_ready} !== {4'd0, 1'b0, 1'b1, 1'b1}) begin
      n_fail++;
      $display("FAIL mid_reset: count/commit/empty/ready=%0d/%b/%b/%b required 0/0/1/1",
               bus.count, bus.commit, bus.empty, bus.issue_ready);
    end
    drive_issue(5'd9, 4'd6);
    step();
    drive_idle();
    drive_cdb(4'd6, 32'h0000_0666);
    step();
    drive_idle();
    n_tests++;
    if ({bus.commit, bus.commit_dest, bus.commit_tag} !== {1'b1, 5'd9, 4'd6}) begin
      n_fail++;
      $display("FAIL after_reset: commit/dest/tag=%b/%0d/%0d required 1/9/6",
               bus.commit, bus.commit_dest, bus.commit_tag);
    end
    step();
  endtask

  initial begin
    rst_n = 1'b0;
    drive_idle();
    test_reset();
    test_single();
    test_out_of_order();
    test_full();
    test_wrap();
    test_same_cycle_and_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/reorder_buf.md
Name: reorder_buf

Overview:
In-order commit buffer for the Tomasulo core. At issue, it allocates one entry per instruction, recording the destination register and the reservation-station tag producing the result. It captures results from the common data bus (CDB) and retires entries strictly in program order. Its commit outputs drive the register file write port and the rename table's commit/clear inputs (commit, destination index, original tag).

Parameters:
DEPTH, 8, number of entries; power of two, minimum 2
PTR_W, 3, log2(DEPTH)
TAG_W, 4, reservation-station tag width; tag 0 means "no producer" and is never allocated
REG_W, 5, architectural register index width
DATA_W, 32, result width

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
issue_valid  in  1  instruction issuing this cycle
issue_dest  in  REG_W  destination register of issuing instruction
issue_tag  in  TAG_W  reservation station assigned at issue (nonzero)
issue_ready  out  1  entry available; issue is accepted only when issue_valid & issue_ready
cdb_valid  in  1  CDB broadcast this cycle
cdb_tag  in  TAG_W  tag of broadcasting reservation station
cdb_value  in  DATA_W  broadcast result
commit  out  1  head entry retiring this cycle
commit_dest  out  REG_W  destination of retiring entry
commit_tag  out  TAG_W  original producer tag of retiring entry
commit_value  out  DATA_W  result of retiring entry
count  out  PTR_W+1  occupied entries
empty  out  1  count == 0

Behaviour:
- Storage: circular buffer of DEPTH entries, each holding busy, done, dest, tag and value.
- Pointers: head_ptr and tail_ptr are PTR_W wide, plus a registered count. Pointers wrap modulo DEPTH.
- Reset (rst_n low at posedge): all busy and done bits cleared, pointers = 0, count = 0. As a result, commit = 0, issue_ready = 1, empty = 1, and commit_dest/commit_tag/commit_value = 0. Reset mid-operation discards all entries.
- issue_ready = (count != DEPTH). It is registered-state based and takes no combinational path from the commit of the same cycle, so a full buffer refuses issue even while committing.
- Issue accept (issue_valid & issue_ready) at a posedge: entry[tail] gets busy=1, done=0, dest, tag; tail increments.
- issue_valid while not ready: ignored, no state change. The upstream is responsible for stalling.
- CDB capture at a posedge: every entry with busy & !done & tag == cdb_tag gets done=1 and value=cdb_value.
  - At most one entry matches, because reservation-station tags are unique among pending entries.
  - cdb_tag == 0 or cdb_valid == 0: no effect.
  - The entry being allocated in the same cycle is not matched. A same-cycle CDB never completes a just-issued entry.
- Commit is combinational from registered state:
  - commit = entry[head].busy & entry[head].done.
  - commit_dest, commit_tag and commit_value show entry[head] fields when commit = 1, else 0.
  - At the posedge with commit = 1: entry[head] is cleared (busy=0, done=0) and head increments.
  - At most one commit per cycle.
- Latency: CDB broadcast in cycle N gives commit = 1 in cycle N+1 at the earliest (when that entry is the head). Issue in cycle N makes the entry visible in count in cycle N+1.
- count update: +1 on issue only, −1 on commit only, unchanged on both or neither. Issue and commit may coexist whenever count is in 1..DEPTH−1.
- Empty buffer: commit = 0. CDB broadcasts have no effect.
- Out-of-order completion: younger done entries wait until all older entries commit.
- Simultaneous issue, CDB and commit in one cycle are all legal and independent.

Decomposition:
- Shared package tomasulo_pkg holds TAG_W, REG_W, DATA_W, the NO_TAG = 0 constant, and the rob_entry_t struct (busy, done, dest, tag, value). The rename table and reservation stations use the same package.
- One natural sub-module: rob_ptr_ctrl, containing the head/tail pointers, wrap logic, count, issue_ready and empty. The entry array and CDB match stay in reorder_buf.

Test Plan:
1. Reset then idle → commit=0, issue_ready=1, empty=1, count=0; a CDB on tag 3 has no effect.
2. Issue (dest=5, tag=2) in cycle 1; CDB (tag=2, value=0xDEADBEEF) in cycle 3 → in cycle 4: commit=1, commit_dest=5, commit_tag=2, commit_value=0xDEADBEEF; in cycle 5: empty=1.
3. Issue A (dest=1, tag=1), then B (dest=2, tag=2); CDB tag 2, then two cycles later CDB tag 1 → no commit until tag 1 arrives; then A commits, B commits the next cycle with commit_dest=2.
4. Issue 8 entries with tags 1..8 → count=8, issue_ready=0. A 9th issue_valid is ignored. CDB tag 1 → commit in the next cycle, and issue_ready=1 in the cycle after.
5. Wrap-around: 20 issue/CDB/commit rounds with a steady occupancy of 3 → commits in order with correct dest/tag/value, and count stays 3.
6. Same-cycle issue (tag=4) with CDB tag=4 → the new entry stays not done. Assert rst_n mid-stream with 5 entries → the next cycle has count=0 and commit=0.
